// File: rtl/mod_updown_counter_pkg.sv
// Shared helpers for the up/down counter: prescaler sizing and parameter legality.
package mod_updown_counter_pkg;

    // Prescaler count width; a single bit is still needed when DIV is 1 or 2.
    function automatic int pc_width(input int div);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(div))
            w++;
        return w;
    endfunction

    function automatic bit params_ok(input int width, input longint unsigned modulus,
                                     input int div);
        return (width >= 1) && (width <= 32) && (modulus >= 2) &&
               (modulus <= (64'd1 << width)) && (div >= 1);
    endfunction

endpackage

// File: rtl/mod_updown_counter_tick_prescaler.sv
// Divides enabled cycles by DIV; tick marks the cycle in which the counter advances.
module tick_prescaler
    import mod_updown_counter_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    if (DIV == 1) begin : g_bypass
        logic unused_ok;
        assign unused_ok = ^{clk, clr};
        // Gated by reset so tick reads low while the block is held in reset.
        assign tick = en & rst_n;
    end else begin : g_div
        localparam int PW = pc_width(DIV);
        localparam logic [PW-1:0] PC_LAST = PW'(DIV - 1);

        logic [PW-1:0] pc;

        assign tick = en & (pc == PC_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pc <= '0;
            end else if (clr) begin
                pc <= '0;
            end else if (en) begin
                pc <= tick ? '0 : pc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down modulus counter with prescaler, load/clear, terminal count and sticky wrap flag.
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH,
    parameter int              DIV     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc,
    output logic             wrap_sticky
);

    if (!params_ok(WIDTH, MODULUS, DIV)) begin : g_bad_params
        $error("mod_updown_counter: illegal WIDTH/MODULUS/DIV combination");
    end

    // With MODULUS == 2**WIDTH this truncates to all-ones, so the wrap is plain overflow.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

    logic at_top;
    logic at_bottom;
    logic [WIDTH-1:0] load_q;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr | load),
        .tick  (tick)
    );

    assign at_top    = (q == MAX_Q);
    assign at_bottom = (q == '0);
    assign load_q    = (64'(load_val) < MODULUS) ? load_val : MAX_Q;

    assign tc = tick & ~clr & ~load & (up ? at_top : at_bottom);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q           <= '0;
            wrap_sticky <= 1'b0;
        end else if (clr) begin
            q           <= '0;
            wrap_sticky <= 1'b0;
        end else if (load) begin
            q <= load_q;
        end else if (tick) begin
            if (up)
                q <= at_top ? '0 : q + 1'b1;
            else
                q <= at_bottom ? MAX_Q : q - 1'b1;
            if (tc)
                wrap_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: BCD digit, prescaled counter and a two-digit cascade.
module tb_mod_updown_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Instance A: WIDTH=4, MODULUS=10, DIV=1
    logic a_en = 0, a_up = 1, a_clr = 0, a_load = 0;
    logic [3:0] a_lv = '0;
    logic [3:0] a_q;
    logic a_tick, a_tc, a_ws;

    // Instance B: WIDTH=4, MODULUS=10, DIV=3
    logic b_en = 0, b_up = 1, b_clr = 0, b_load = 0;
    logic [3:0] b_lv = '0;
    logic [3:0] b_q;
    logic b_tick, b_tc, b_ws;

    // Cascade: low digit tc drives high digit en
    logic c_en = 0, c_clr = 0;
    logic [3:0] lo_q, hi_q;
    logic lo_tick, lo_tc, lo_ws, hi_tick, hi_tc, hi_ws;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(1)) u_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .up(a_up), .clr(a_clr), .load(a_load),
        .load_val(a_lv), .q(a_q), .tick(a_tick), .tc(a_tc), .wrap_sticky(a_ws));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(3)) u_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .up(b_up), .clr(b_clr), .load(b_load),
        .load_val(b_lv), .q(b_q), .tick(b_tick), .tc(b_tc), .wrap_sticky(b_ws));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(1)) u_lo (
        .clk(clk), .rst_n(rst_n), .en(c_en), .up(1'b1), .clr(c_clr), .load(1'b0),
        .load_val(4'd0), .q(lo_q), .tick(lo_tick), .tc(lo_tc), .wrap_sticky(lo_ws));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(1)) u_hi (
        .clk(clk), .rst_n(rst_n), .en(lo_tc), .up(1'b1), .clr(c_clr), .load(1'b0),
        .load_val(4'd0), .q(hi_q), .tick(hi_tick), .tc(hi_tc), .wrap_sticky(hi_ws));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (a_q !== 4'd0) $display("FAIL reset_a_q got %0d want 0", a_q); else n_pass++;
        n_checks++; if (a_ws !== 1'b0) $display("FAIL reset_a_ws got %b want 0", a_ws); else n_pass++;
        n_checks++; if (a_tick !== 1'b0) $display("FAIL reset_a_tick got %b want 0", a_tick); else n_pass++;
        n_checks++; if (a_tc !== 1'b0) $display("FAIL reset_a_tc got %b want 0", a_tc); else n_pass++;
        n_checks++; if (b_q !== 4'd0) $display("FAIL reset_b_q got %0d want 0", b_q); else n_pass++;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_count_up();
        a_up = 1'b1;
        a_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_checks++;
            if (a_q !== 4'(i % 10)) $display("FAIL up_q[%0d] got %0d want %0d", i, a_q, i % 10);
            else n_pass++;
            n_checks++;
            if (a_tc !== ((i % 10) == 9)) $display("FAIL up_tc[%0d] got %b want %b", i, a_tc, (i % 10) == 9);
            else n_pass++;
            n_checks++;
            if (a_ws !== (i >= 10)) $display("FAIL up_ws[%0d] got %b want %b", i, a_ws, i >= 10);
            else n_pass++;
            n_checks++;
            if (a_tick !== 1'b1) $display("FAIL up_tick[%0d] got %b want 1", i, a_tick);
            else n_pass++;
            cyc();
        end
        a_en = 1'b0;
    endtask

    task automatic test_count_down();
        a_clr = 1'b1;
        cyc();
        a_clr = 1'b0;
        n_checks++; if (a_q !== 4'd0) $display("FAIL clr_q got %0d want 0", a_q); else n_pass++;
        n_checks++; if (a_ws !== 1'b0) $display("FAIL clr_ws got %b want 0", a_ws); else n_pass++;
        a_up = 1'b0;
        a_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (a_q !== ((i == 0) ? 4'd0 : 4'(10 - i))) $display("FAIL dn_q[%0d] got %0d want %0d", i, a_q, (i == 0) ? 0 : 10 - i);
            else n_pass++;
            n_checks++;
            if (a_tc !== (i == 0)) $display("FAIL dn_tc[%0d] got %b want %b", i, a_tc, i == 0);
            else n_pass++;
            n_checks++;
            if (a_ws !== (i >= 1)) $display("FAIL dn_ws[%0d] got %b want %b", i, a_ws, i >= 1);
            else n_pass++;
            cyc();
        end
        a_en = 1'b0;
    endtask

    task automatic test_load();
        a_clr = 1'b1;
        cyc();
        a_clr = 1'b0;
        // q=0 counting down with tick=1 would wrap, but load takes priority
        a_up = 1'b0; a_en = 1'b1; a_load = 1'b1; a_lv = 4'd13;
        #1;
        n_checks++; if (a_tc !== 1'b0) $display("FAIL load_tc got %b want 0", a_tc); else n_pass++;
        cyc();
        a_load = 1'b0; a_en = 1'b0;
        n_checks++; if (a_q !== 4'd9) $display("FAIL load_clamp_q got %0d want 9", a_q); else n_pass++;
        n_checks++; if (a_ws !== 1'b0) $display("FAIL load_ws got %b want 0", a_ws); else n_pass++;
        a_load = 1'b1; a_lv = 4'd6;
        cyc();
        a_load = 1'b0;
        n_checks++; if (a_q !== 4'd6) $display("FAIL load_in_range got %0d want 6", a_q); else n_pass++;
        a_load = 1'b1; a_lv = 4'd9;
        cyc();
        a_load = 1'b0;
        a_up = 1'b1; a_en = 1'b1;
        cyc();
        a_en = 1'b0;
        n_checks++; if (a_ws !== 1'b1) $display("FAIL wrap_set_ws got %b want 1", a_ws); else n_pass++;
        a_clr = 1'b1; a_load = 1'b1; a_lv = 4'd5; a_en = 1'b1;
        cyc();
        a_clr = 1'b0; a_load = 1'b0; a_en = 1'b0;
        n_checks++; if (a_q !== 4'd0) $display("FAIL clr_over_load_q got %0d want 0", a_q); else n_pass++;
        n_checks++; if (a_ws !== 1'b0) $display("FAIL clr_over_load_ws got %b want 0", a_ws); else n_pass++;
    endtask

    task automatic test_prescaler();
        b_clr = 1'b1;
        cyc();
        b_clr = 1'b0;
        b_up = 1'b1;
        b_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_checks++;
            if (b_tick !== ((k % 3) == 2)) $display("FAIL pre_tick[%0d] got %b want %b", k, b_tick, (k % 3) == 2);
            else n_pass++;
            n_checks++;
            if (b_q !== 4'(k / 3)) $display("FAIL pre_q[%0d] got %0d want %0d", k, b_q, k / 3);
            else n_pass++;
            cyc();
        end
        cyc();
        b_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if (b_tick !== 1'b0) $display("FAIL hold_tick[%0d] got %b want 0", k, b_tick); else n_pass++;
            n_checks++; if (b_q !== 4'd2) $display("FAIL hold_q[%0d] got %0d want 2", k, b_q); else n_pass++;
            cyc();
        end
        b_en = 1'b1;
        #1;
        n_checks++; if (b_tick !== 1'b0) $display("FAIL resume_tick0 got %b want 0", b_tick); else n_pass++;
        cyc();
        n_checks++; if (b_tick !== 1'b1) $display("FAIL resume_tick1 got %b want 1", b_tick); else n_pass++;
        n_checks++; if (b_q !== 4'd2) $display("FAIL resume_q0 got %0d want 2", b_q); else n_pass++;
        cyc();
        b_en = 1'b0;
        n_checks++; if (b_q !== 4'd3) $display("FAIL resume_q1 got %0d want 3", b_q); else n_pass++;
    endtask

    task automatic test_async_reset();
        b_load = 1'b1; b_lv = 4'd7;
        cyc();
        b_load = 1'b0;
        n_checks++; if (b_q !== 4'd7) $display("FAIL prereset_q got %0d want 7", b_q); else n_pass++;
        b_en = 1'b1;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (b_q !== 4'd0) $display("FAIL async_q got %0d want 0", b_q); else n_pass++;
        n_checks++; if (b_tick !== 1'b0) $display("FAIL async_tick got %b want 0", b_tick); else n_pass++;
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            cyc();
            n_checks++;
            if (b_q !== ((e == 3) ? 4'd1 : 4'd0)) $display("FAIL post_reset_q[%0d] got %0d want %0d", e, b_q, (e == 3) ? 1 : 0);
            else n_pass++;
        end
        b_en = 1'b0;
    endtask

    task automatic test_cascade();
        c_clr = 1'b1;
        cyc();
        c_clr = 1'b0;
        c_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (i == 50) begin
                n_checks++; if (lo_q !== 4'd0 || hi_q !== 4'd5) $display("FAIL casc_mid got lo=%0d hi=%0d want lo=0 hi=5", lo_q, hi_q); else n_pass++;
                n_checks++; if (hi_ws !== 1'b0) $display("FAIL casc_mid_ws got %b want 0", hi_ws); else n_pass++;
            end
            if (i == 99) begin
                n_checks++; if (lo_q !== 4'd9 || hi_q !== 4'd9) $display("FAIL casc_99 got lo=%0d hi=%0d want 9 9", lo_q, hi_q); else n_pass++;
                n_checks++; if (hi_tc !== 1'b1) $display("FAIL casc_hi_tc got %b want 1", hi_tc); else n_pass++;
            end
            cyc();
        end
        c_en = 1'b0;
        n_checks++; if (lo_q !== 4'd0 || hi_q !== 4'd0) $display("FAIL casc_end got lo=%0d hi=%0d want 0 0", lo_q, hi_q); else n_pass++;
        n_checks++; if (hi_ws !== 1'b1) $display("FAIL casc_hi_ws got %b want 1", hi_ws); else n_pass++;
        n_checks++; if (hi_tc !== 1'b0) $display("FAIL casc_hi_tc_idle got %b want 0", hi_tc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_prescaler();
        test_async_reset();
        test_cascade();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
